line_encoder_4_2: RTL and testbench
===================================

# line_encoder_4_2

Sequential 4-to-2 encoder: the inverse of the team's 2-to-4 line decoder. Request strobes on lines D0..D3 are captured into a sticky pending register. The block then issues one 2-bit code per accepted transfer on a VALID/READY handshake and clears each served line. Its output fields A1 (MSB) and A2 (LSB) drive the decoder's A1/A2 inputs directly, so decoding an issued code reasserts the originating line.

## Interface
- PRIO_HIGH, default 1; 1 = D3 highest priority, 0 = D0 highest priority.
- CLK  in  1  single clock; all state changes on its rising edge.
- RST_N  in  1  synchronous, active-low reset.
- EN  in  1  request-capture enable; D0..D3 are ignored while EN=0.
- D0, D1, D2, D3  in  1 each  request lines, sampled every cycle.
- READY  in  1  consumer accepts the code on the current cycle.
- VALID  out  1  a code is presented on A1/A2.
- A1  out  1  code MSB.
- A2  out  1  code LSB; Dn encodes to {A1,A2} = n.
- PEND  out  4  pending register, bit n = line Dn awaiting issue (excludes the code currently on VALID).
- DUP  out  1  one-cycle pulse: a request was merged into one already outstanding.
- BUSY  out  1  PEND != 0 or VALID = 1; derived from registers only.

## Operation
- new[n] = Dn & EN, evaluated each cycle.
- slot_free = !VALID | READY.
- cand = PEND | new.
- On a rising edge with RST_N=1:
  - If slot_free and cand != 0:
    - pick = highest-priority set bit of cand, per PRIO_HIGH.
    - VALID <= 1, {A1,A2} <= pick.
    - PEND <= cand with bit pick cleared.
  - If slot_free and cand == 0: VALID <= 0; A1/A2 hold their last value; PEND unchanged.
  - If !slot_free: VALID, A1, A2 hold; PEND <= cand.
- Handshake:
  - A transfer occurs on any edge with VALID & READY.
  - While VALID=1 and READY=0, A1/A2 are stable until the transfer.
  - READY while VALID=0 has no effect.
- Duplicate rule: DUP <= 1 for one cycle if some new[n]=1 and either:
  - PEND[n]=1, or
  - VALID=1, code==n and READY=0.
  - The request merges and is issued once.
- A new[n] arriving in the same cycle that code n transfers (VALID & READY) is a fresh request: it enters cand and may be reissued immediately; no DUP.
- Fixed priority: a continuously held top-priority line starves the others. This is intended; no fairness.
- Reset (RST_N=0 at an edge) overrides everything, including mid-handshake and pending lines:
  - PEND=0, VALID=0, A1=0, A2=0, DUP=0, hence BUSY=0.
  - Requests present during reset are discarded.

## Timing
- Latency: Dn high at edge k (slot free) -> VALID=1 with code n after edge k.
- Throughput: one code per cycle with READY held high.
- Draining a 4-bit burst takes 4 transfers.
- DUP is registered and appears the cycle after the offending sample.
- All outputs come from flops except BUSY, which is an OR of flops.
- No combinational path from any input to any output.

## Structure
- Package line_enc_pkg holds:
  - code constants CODE_D0..CODE_D3 = 2'd0..2'd3;
  - the 4-bit request vector typedef;
  - the PRIO_HIGH encoding.
- Sub-module prio_pick_4 (combinational):
  - inputs: 4-bit vector and PRIO_HIGH;
  - outputs: 2-bit index and a nonzero flag.
- All state lives in line_encoder_4_2: PEND, VALID/A1/A2, DUP.

## Test plan
- Reset: hold RST_N=0 for 2 cycles with D=4'b1111, EN=1 -> after release VALID=0, PEND=0, A1A2=00, BUSY=0.
- Single request: EN=1, pulse D2 one cycle, READY=1 -> next cycle VALID=1, {A1,A2}=10; following cycle VALID=0, BUSY=0.
- Burst with backpressure, PRIO_HIGH=1:
  - D0..D3 pulsed together, READY=0 for 3 cycles -> code 11 held stable, PEND=0111.
  - READY=1 -> codes 11, 10, 01, 00 on consecutive cycles.
- PRIO_HIGH=0, same burst -> issue order 00, 01, 10, 11.
- Duplicates:
  - Pulse D1 twice while code 01 is stalled (READY=0) -> DUP pulses once; 01 issued once.
  - Pulse D1 on the transfer cycle of 01 -> no DUP; 01 issued again next cycle.
- EN=0 with D=1111 -> PEND unchanged, no VALID.
- Reset mid-burst with PEND=0110 and VALID=1 -> all state cleared on the next edge.

Source files
------------

// File: rtl/line_enc_pkg.sv
// Shared types and constants for the sequential 4-to-2 line encoder.
// Codes match the 2-to-4 decoder's {A1,A2} input so a decoded code reasserts its line.
package line_enc_pkg;

  localparam logic [1:0] CODE_D0 = 2'd0;
  localparam logic [1:0] CODE_D1 = 2'd1;
  localparam logic [1:0] CODE_D2 = 2'd2;
  localparam logic [1:0] CODE_D3 = 2'd3;

  typedef logic [3:0] req_vec_t;

  // PRIO_HIGH encoding: which end of the request vector wins.
  localparam bit PRIO_D3_FIRST = 1'b1;
  localparam bit PRIO_D0_FIRST = 1'b0;

  function automatic req_vec_t code_mask(input logic [1:0] code);
    return req_vec_t'(4'b0001 << code);
  endfunction

endpackage

// File: rtl/prio_pick_4.sv
// Combinational fixed-priority picker over a 4-bit request vector.
// prio_high=1 selects the highest set index, 0 selects the lowest.
module prio_pick_4
  import line_enc_pkg::*;
(
  input  req_vec_t   vec,
  input  logic       prio_high,
  output logic [1:0] idx,
  output logic       nonzero
);

  // NOTE: idx gets a default before the loops so no path leaves it unassigned (no latch).
  always_comb begin
    idx     = CODE_D0;
    nonzero = |vec;
    if (prio_high) begin
      for (int i = 0; i < 4; i++) begin
        if (vec[i]) idx = 2'(i);
      end
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (vec[i]) idx = 2'(i);
      end
    end
  end

endmodule

// File: rtl/line_encoder_4_2.sv
// Sequential 4-to-2 encoder: sticky request capture, one code per VALID/READY
// transfer, duplicate-merge detection. All outputs registered except BUSY.
module line_encoder_4_2
  import line_enc_pkg::*;
#(
  parameter bit PRIO_HIGH = PRIO_D3_FIRST
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EN,
  input  logic       D0,
  input  logic       D1,
  input  logic       D2,
  input  logic       D3,
  input  logic       READY,
  output logic       VALID,
  output logic       A1,
  output logic       A2,
  output logic [3:0] PEND,
  output logic       DUP,
  output logic       BUSY
);

  req_vec_t   new_req;
  req_vec_t   held_mask;
  req_vec_t   cand;
  logic       slot_free;
  logic       pick_nz;
  logic [1:0] pick_idx;

  always_comb begin
    new_req   = {D3, D2, D1, D0} & {4{EN}};
    slot_free = !VALID || READY;
    // A stalled code absorbs repeat requests for its own line.
    held_mask = (VALID && !READY) ? code_mask({A1, A2}) : '0;
    cand      = PEND | new_req;
  end

  prio_pick_4 u_pick (
    .vec       (cand),
    .prio_high (PRIO_HIGH),
    .idx       (pick_idx),
    .nonzero   (pick_nz)
  );

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      PEND  <= '0;
      VALID <= 1'b0;
      A1    <= 1'b0;
      A2    <= 1'b0;
      DUP   <= 1'b0;
    end else begin
      DUP <= |(new_req & (PEND | held_mask));
      if (slot_free) begin
        if (pick_nz) begin
          VALID    <= 1'b1;
          {A1, A2} <= pick_idx;
          PEND     <= cand & ~code_mask(pick_idx);
        end else begin
          VALID <= 1'b0;
        end
      end else begin
        PEND <= cand & ~held_mask;
      end
    end
  end

  assign BUSY = VALID || (|PEND);

endmodule

// File: tb/tb_line_encoder_4_2.sv
// Scoreboard bench for line_encoder_4_2: one instance per priority order,
// expected codes queued at stimulus time and popped on each observed transfer.
module tb_line_encoder_4_2;

  logic       clk = 1'b0;
  logic       rst_n, rst_n1, en, ready;
  logic [3:0] d;

  logic       valid0, a1_0, a2_0, dup0, busy0;
  logic [3:0] pend0;
  logic       valid1, a1_1, a2_1, dup1, busy1;
  logic [3:0] pend1;
  logic [1:0] code0, code1, exp0, exp1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] sb0[$];
  logic [1:0] sb1[$];

  assign code0 = {a1_0, a2_0};
  assign code1 = {a1_1, a2_1};

  always #5 clk = ~clk;

  line_encoder_4_2 #(.PRIO_HIGH(1'b1)) dut_hi (
    .CLK(clk), .RST_N(rst_n), .EN(en),
    .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]), .READY(ready),
    .VALID(valid0), .A1(a1_0), .A2(a2_0), .PEND(pend0), .DUP(dup0), .BUSY(busy0)
  );

  line_encoder_4_2 #(.PRIO_HIGH(1'b0)) dut_lo (
    .CLK(clk), .RST_N(rst_n1), .EN(en),
    .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]), .READY(ready),
    .VALID(valid1), .A1(a1_1), .A2(a2_1), .PEND(pend1), .DUP(dup1), .BUSY(busy1)
  );

  // Transfer monitors: a code crosses on the coming edge when VALID & READY.
  always @(negedge clk) begin
    if (valid0 && ready) begin
      n_checks++;
      if (sb0.size() == 0) begin
        n_fail++;
        $display("FAIL xfer_hi: got code %0d, expected no transfer", code0);
      end else begin
        exp0 = sb0.pop_front();
        if (code0 !== exp0) begin
          n_fail++;
          $display("FAIL xfer_hi: got code %0d, expected %0d", code0, exp0);
        end
      end
    end
    if (valid1 && ready) begin
      n_checks++;
      if (sb1.size() == 0) begin
        n_fail++;
        $display("FAIL xfer_lo: got code %0d, expected no transfer", code1);
      end else begin
        exp1 = sb1.pop_front();
        if (code1 !== exp1) begin
          n_fail++;
          $display("FAIL xfer_lo: got code %0d, expected %0d", code1, exp1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    rst_n = 1'b1;
    d     = 4'b0000;
    n_checks++;
    if ({valid0, code0, pend0, busy0, dup0} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%0b c=%0d p=%b b=%0b dup=%0b, expected all 0",
               valid0, code0, pend0, busy0, dup0);
    end
    tick();
    n_checks++;
    if ({valid0, pend0, busy0, valid1, busy1} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got v=%0b p=%b b=%0b v1=%0b b1=%0b, expected all 0",
               valid0, pend0, busy0, valid1, busy1);
    end
  endtask

  task automatic test_single();
    ready = 1'b1;
    d     = 4'b0100;
    sb0.push_back(2'd2);
    tick();
    d = 4'b0000;
    n_checks++;
    if ({valid0, code0, pend0, busy0} !== {1'b1, 2'd2, 4'b0000, 1'b1}) begin
      n_fail++;
      $display("FAIL single_issue: got v=%0b c=%0d p=%b b=%0b, expected v=1 c=2 p=0000 b=1",
               valid0, code0, pend0, busy0);
    end
    tick();
    n_checks++;
    if ({valid0, busy0} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_done: got v=%0b b=%0b, expected 0 0", valid0, busy0);
    end
  endtask

  task automatic test_burst_high();
    ready = 1'b0;
    d     = 4'b1111;
    sb0.push_back(2'd3); sb0.push_back(2'd2); sb0.push_back(2'd1); sb0.push_back(2'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      d = 4'b0000;
      n_checks++;
      if ({valid0, code0, pend0} !== {1'b1, 2'd3, 4'b0111}) begin
        n_fail++;
        $display("FAIL burst_stall[%0d]: got v=%0b c=%0d p=%b, expected v=1 c=3 p=0111",
                 i, valid0, code0, pend0);
      end
    end
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({valid0, code0} !== {1'b1, 2'(2 - i)}) begin
        n_fail++;
        $display("FAIL burst_drain[%0d]: got v=%0b c=%0d, expected v=1 c=%0d",
                 i, valid0, code0, 2 - i);
      end
    end
    tick();
    n_checks++;
    if ({valid0, busy0} !== 2'b00) begin
      n_fail++;
      $display("FAIL burst_end: got v=%0b b=%0b, expected 0 0", valid0, busy0);
    end
  endtask

  task automatic test_prio_low();
    rst_n1 = 1'b1;
    d      = 4'b0000;
    ready  = 1'b0;
    tick();
    d = 4'b1111;
    sb0.push_back(2'd3); sb0.push_back(2'd2); sb0.push_back(2'd1); sb0.push_back(2'd0);
    sb1.push_back(2'd0); sb1.push_back(2'd1); sb1.push_back(2'd2); sb1.push_back(2'd3);
    tick();
    d = 4'b0000;
    n_checks++;
    if ({valid1, code1, pend1, code0, pend0} !== {1'b1, 2'd0, 4'b1110, 2'd3, 4'b0111}) begin
      n_fail++;
      $display("FAIL prio_first: got lo v=%0b c=%0d p=%b hi c=%0d p=%b, expected 1 0 1110 3 0111",
               valid1, code1, pend1, code0, pend0);
    end
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({valid1, code1} !== {1'b1, 2'(i + 1)}) begin
        n_fail++;
        $display("FAIL prio_lo_drain[%0d]: got v=%0b c=%0d, expected v=1 c=%0d",
                 i, valid1, code1, i + 1);
      end
    end
    tick();
    n_checks++;
    if ({valid0, valid1, busy0, busy1} !== 4'b0000) begin
      n_fail++;
      $display("FAIL prio_end: got v0=%0b v1=%0b b0=%0b b1=%0b, expected 0",
               valid0, valid1, busy0, busy1);
    end
  endtask

  task automatic test_dup();
    ready = 1'b0;
    d     = 4'b0010;
    sb0.push_back(2'd1);
    sb1.push_back(2'd1);
    tick();
    d = 4'b0000;
    n_checks++;
    if ({valid0, code0, dup0} !== {1'b1, 2'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL dup_first: got v=%0b c=%0d dup=%0b, expected 1 1 0", valid0, code0, dup0);
    end
    tick();
    d = 4'b0010;
    tick();
    d = 4'b0000;
    n_checks++;
    if ({dup0, pend0, dup1, pend1} !== {1'b1, 4'b0000, 1'b1, 4'b0000}) begin
      n_fail++;
      $display("FAIL dup_pulse: got dup=%0b p=%b dup1=%0b p1=%b, expected 1 0000 1 0000",
               dup0, pend0, dup1, pend1);
    end
    tick();
    n_checks++;
    if ({dup0, dup1, valid0, code0} !== {1'b0, 1'b0, 1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL dup_clear: got dup=%0b dup1=%0b v=%0b c=%0d, expected 0 0 1 1",
               dup0, dup1, valid0, code0);
    end
    ready = 1'b1;
    tick();
    n_checks++;
    if ({valid0, valid1, busy0} !== 3'b000) begin
      n_fail++;
      $display("FAIL dup_once: got v0=%0b v1=%0b b0=%0b, expected 0 0 0", valid0, valid1, busy0);
    end
    // Same line requested on its own transfer cycle is a fresh request.
    ready = 1'b0;
    d     = 4'b0010;
    sb0.push_back(2'd1);
    sb1.push_back(2'd1);
    tick();
    d     = 4'b0010;
    ready = 1'b1;
    sb0.push_back(2'd1);
    sb1.push_back(2'd1);
    tick();
    d = 4'b0000;
    n_checks++;
    if ({valid0, code0, dup0, dup1} !== {1'b1, 2'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL dup_fresh: got v=%0b c=%0d dup=%0b dup1=%0b, expected 1 1 0 0",
               valid0, code0, dup0, dup1);
    end
    tick();
    n_checks++;
    if ({valid0, valid1} !== 2'b00) begin
      n_fail++;
      $display("FAIL dup_fresh_end: got v0=%0b v1=%0b, expected 0 0", valid0, valid1);
    end
  endtask

  task automatic test_en_off();
    en    = 1'b0;
    d     = 4'b1111;
    ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({valid0, pend0, busy0, valid1} !== 7'b0) begin
      n_fail++;
      $display("FAIL en_idle: got v=%0b p=%b b=%0b v1=%0b, expected all 0",
               valid0, pend0, busy0, valid1);
    end
    en    = 1'b1;
    d     = 4'b0011;
    ready = 1'b0;
    sb0.push_back(2'd1); sb0.push_back(2'd0);
    sb1.push_back(2'd0); sb1.push_back(2'd1);
    tick();
    en = 1'b0;
    d  = 4'b1111;
    tick();
    tick();
    n_checks++;
    if ({pend0, pend1, valid0, code0, dup0} !== {4'b0001, 4'b0010, 1'b1, 2'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL en_hold: got p=%b p1=%b v=%0b c=%0d dup=%0b, expected 0001 0010 1 1 0",
               pend0, pend1, valid0, code0, dup0);
    end
    en    = 1'b1;
    d     = 4'b0000;
    ready = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({valid0, valid1, busy0, busy1} !== 4'b0000) begin
      n_fail++;
      $display("FAIL en_drain: got v0=%0b v1=%0b b0=%0b b1=%0b, expected 0",
               valid0, valid1, busy0, busy1);
    end
  endtask

  task automatic test_reset_mid();
    ready = 1'b0;
    d     = 4'b1110;
    tick();
    d = 4'b0000;
    n_checks++;
    if ({valid0, code0, pend0} !== {1'b1, 2'd3, 4'b0110}) begin
      n_fail++;
      $display("FAIL mid_setup: got v=%0b c=%0d p=%b, expected 1 3 0110", valid0, code0, pend0);
    end
    rst_n  = 1'b0;
    rst_n1 = 1'b0;
    d      = 4'b1111;
    tick();
    n_checks++;
    if ({valid0, code0, pend0, dup0, busy0, valid1, code1, pend1, busy1} !== 16'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%0b c=%0d p=%b dup=%0b b=%0b v1=%0b c1=%0d p1=%b b1=%0b, expected all 0",
               valid0, code0, pend0, dup0, busy0, valid1, code1, pend1, busy1);
    end
    rst_n  = 1'b1;
    rst_n1 = 1'b1;
    d      = 4'b0000;
    tick();
    n_checks++;
    if ({valid0, busy0, valid1, busy1} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_after: got v=%0b b=%0b v1=%0b b1=%0b, expected 0",
               valid0, busy0, valid1, busy1);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    rst_n1 = 1'b0;
    en     = 1'b1;
    d      = 4'b1111;
    ready  = 1'b0;
    test_reset();
    test_single();
    test_burst_high();
    test_prio_low();
    test_dup();
    test_en_off();
    test_reset_mid();
    n_checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d/%0d codes never issued, expected 0/0",
               sb0.size(), sb1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
